// File: rtl/game_flow_controller.sv
// Game sequencer: owns the screen code, lives and gold counts, and frame-timed
// pauses; drives freeze/new_game to the moving-object units.
module game_flow_controller #(
    parameter int LIVES_INIT   = 3,
    parameter int GOLD_TOTAL   = 8,
    parameter int DEATH_FRAMES = 60,
    parameter int END_FRAMES   = 180,
    parameter int BLANK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       start_key,
    input  logic       player_hit,
    input  logic       gold_collected,
    output logic [2:0] game_state,
    output logic [1:0] lives_left,
    output logic [3:0] gold_left,
    output logic       freeze,
    output logic       new_game
);

    localparam logic [2:0] ST_BLANK = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_DEATH = 3'd3;
    localparam logic [2:0] ST_WIN   = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [3:0] GOLD_LOAD  = 4'(GOLD_TOTAL);
    localparam logic [7:0] BLANK_CNT  = 8'(BLANK_FRAMES);
    localparam logic [7:0] DEATH_CNT  = 8'(DEATH_FRAMES);
    localparam logic [7:0] END_CNT    = 8'(END_FRAMES);

    logic [2:0] state, state_nxt;
    logic [7:0] frame_cnt;
    logic       start_key_d;
    logic       key_edge;
    logic [1:0] lives_nxt;
    logic [3:0] gold_nxt;
    logic       new_game_nxt;

    assign key_edge = start_key & ~start_key_d;

    // Screen code seen by the pixel mux; DEATH keeps showing the play field.
    function automatic logic [2:0] screen_code(input logic [2:0] s);
        case (s)
            ST_START:         return 3'd1;
            ST_PLAY, ST_DEATH: return 3'd2;
            ST_WIN:           return 3'd3;
            ST_OVER:          return 3'd4;
            default:          return 3'd0;
        endcase
    endfunction

    always_comb begin
        state_nxt    = state;
        lives_nxt    = lives_left;
        gold_nxt     = gold_left;
        new_game_nxt = 1'b0;
        case (state)
            ST_BLANK: begin
                if (frame_cnt == BLANK_CNT) state_nxt = ST_START;
            end
            ST_START: begin
                if (key_edge) begin
                    state_nxt    = ST_PLAY;
                    new_game_nxt = 1'b1;
                    lives_nxt    = LIVES_LOAD;
                    gold_nxt     = GOLD_LOAD;
                end
            end
            ST_PLAY: begin
                // A hit wins over a simultaneous gold pickup, which is discarded.
                if (player_hit) begin
                    if (lives_left <= 2'd1) begin
                        lives_nxt = 2'd0;
                        state_nxt = ST_OVER;
                    end else begin
                        lives_nxt = lives_left - 2'd1;
                        state_nxt = ST_DEATH;
                    end
                end else if (gold_collected && gold_left != 4'd0) begin
                    gold_nxt = gold_left - 4'd1;
                    if (gold_left == 4'd1) state_nxt = ST_WIN;
                end
            end
            ST_DEATH: begin
                if (frame_cnt == DEATH_CNT) begin
                    state_nxt    = ST_PLAY;
                    new_game_nxt = 1'b1;
                end
            end
            ST_WIN, ST_OVER: begin
                if (frame_cnt == END_CNT || key_edge) state_nxt = ST_START;
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= ST_BLANK;
            frame_cnt   <= 8'd0;
            start_key_d <= 1'b0;
            game_state  <= 3'd0;
            lives_left  <= LIVES_LOAD;
            gold_left   <= GOLD_LOAD;
            freeze      <= 1'b1;
            new_game    <= 1'b0;
        end else begin
            state       <= state_nxt;
            start_key_d <= start_key;
            lives_left  <= lives_nxt;
            gold_left   <= gold_nxt;
            new_game    <= new_game_nxt;
            game_state  <= screen_code(state_nxt);
            freeze      <= (state_nxt != ST_PLAY);
            // Counter restarts on every state entry so each dwell is timed from zero.
            if (state_nxt != state)
                frame_cnt <= 8'd0;
            else if (startOfFrame)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: every cycle's expected output
// vector {game_state, lives, gold, freeze, new_game} is queued and compared.
module tb_game_flow_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       start_key;
    logic       player_hit;
    logic       gold_collected;
    logic [2:0] game_state;
    logic [1:0] lives_left;
    logic [3:0] gold_left;
    logic       freeze;
    logic       new_game;

    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    game_flow_controller dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .start_key     (start_key),
        .player_hit    (player_hit),
        .gold_collected(gold_collected),
        .game_state    (game_state),
        .lives_left    (lives_left),
        .gold_left     (gold_left),
        .freeze        (freeze),
        .new_game      (new_game)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [10:0] pack(input logic [2:0] gs, input logic [1:0] lv,
                                         input logic [3:0] gd, input logic fz,
                                         input logic ng);
        return {gs, lv, gd, fz, ng};
    endfunction

    task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got gs=%0d lives=%0d gold=%0d frz=%0b ng=%0b, want gs=%0d lives=%0d gold=%0d frz=%0b ng=%0b",
                      tag, obs[10:8], obs[7:6], obs[5:2], obs[1], obs[0],
                      exp[10:8], exp[7:6], exp[5:2], exp[1], exp[0]);
    endtask

    // driver: apply one cycle of pulses, queue the expected result, compare after the edge
    task automatic cycle(input string tag, input logic sof, input logic hit,
                         input logic gold, input logic [10:0] exp);
        startOfFrame   = sof;
        player_hit     = hit;
        gold_collected = gold;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        startOfFrame   = 1'b0;
        player_hit     = 1'b0;
        gold_collected = 1'b0;
        check_eq(tag, {game_state, lives_left, gold_left, freeze, new_game}, exp_q.pop_front());
    endtask

    // n frames (pulse + idle cycle); the state change shows after the idle cycle of frame n
    task automatic frames(input string tag, input int n, input logic [10:0] cur,
                          input logic [10:0] nxt);
        for (int k = 1; k <= n; k++) begin
            cycle(tag, 1'b1, 1'b0, 1'b0, cur);
            cycle(tag, 1'b0, 1'b0, 1'b0, (k == n) ? nxt : cur);
        end
    endtask

    initial begin
        logic [10:0] rst_v;
        rst_v          = pack(3'd0, 2'd3, 4'd8, 1'b1, 1'b0);
        resetN         = 1'b0;
        start_key      = 1'b1;
        startOfFrame   = 1'b0;
        player_hit     = 1'b0;
        gold_collected = 1'b0;

        // 1: reset, blank dwell, held key must not start play
        cycle("reset0", 1'b0, 1'b0, 1'b0, rst_v);
        cycle("reset1", 1'b0, 1'b0, 1'b0, rst_v);
        resetN = 1'b1;
        frames("blank", 2, rst_v, pack(3'd1, 2'd3, 4'd8, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            cycle("held_key", 1'b0, 1'b0, 1'b0, pack(3'd1, 2'd3, 4'd8, 1'b1, 1'b0));
        start_key = 1'b0;
        cycle("key_release", 1'b0, 1'b0, 1'b0, pack(3'd1, 2'd3, 4'd8, 1'b1, 1'b0));

        // 2: press starts play with a single new_game pulse
        start_key = 1'b1;
        cycle("press_play", 1'b0, 1'b0, 1'b0, pack(3'd2, 2'd3, 4'd8, 1'b0, 1'b1));
        cycle("ng_one_cycle", 1'b0, 1'b0, 1'b0, pack(3'd2, 2'd3, 4'd8, 1'b0, 1'b0));

        // 3: collect all gold, win, timed return to start
        for (int i = 1; i <= 8; i++)
            cycle("gold", 1'b0, 1'b0, 1'b1,
                  pack((i == 8) ? 3'd3 : 3'd2, 2'd3, 4'(8 - i), (i == 8), 1'b0));
        cycle("win_gold_drop", 1'b0, 1'b0, 1'b1, pack(3'd3, 2'd3, 4'd0, 1'b1, 1'b0));
        frames("win_dwell", 180, pack(3'd3, 2'd3, 4'd0, 1'b1, 1'b0),
               pack(3'd1, 2'd3, 4'd0, 1'b1, 1'b0));
        cycle("start_gold_drop", 1'b0, 1'b0, 1'b1, pack(3'd1, 2'd3, 4'd0, 1'b1, 1'b0));

        // 4: hits, death pauses, game over
        start_key = 1'b0;
        cycle("rel2", 1'b0, 1'b0, 1'b0, pack(3'd1, 2'd3, 4'd0, 1'b1, 1'b0));
        start_key = 1'b1;
        cycle("press2", 1'b0, 1'b0, 1'b0, pack(3'd2, 2'd3, 4'd8, 1'b0, 1'b1));
        cycle("play2", 1'b0, 1'b0, 1'b0, pack(3'd2, 2'd3, 4'd8, 1'b0, 1'b0));
        cycle("hit1", 1'b0, 1'b1, 1'b0, pack(3'd2, 2'd2, 4'd8, 1'b1, 1'b0));
        frames("death1", 60, pack(3'd2, 2'd2, 4'd8, 1'b1, 1'b0),
               pack(3'd2, 2'd2, 4'd8, 1'b0, 1'b1));
        cycle("resume1", 1'b0, 1'b0, 1'b0, pack(3'd2, 2'd2, 4'd8, 1'b0, 1'b0));
        cycle("hit2", 1'b0, 1'b1, 1'b0, pack(3'd2, 2'd1, 4'd8, 1'b1, 1'b0));
        frames("death2", 60, pack(3'd2, 2'd1, 4'd8, 1'b1, 1'b0),
               pack(3'd2, 2'd1, 4'd8, 1'b0, 1'b1));
        cycle("resume2", 1'b0, 1'b0, 1'b0, pack(3'd2, 2'd1, 4'd8, 1'b0, 1'b0));
        cycle("gold_play", 1'b0, 1'b0, 1'b1, pack(3'd2, 2'd1, 4'd7, 1'b0, 1'b0));
        cycle("hit3_over", 1'b0, 1'b1, 1'b0, pack(3'd4, 2'd0, 4'd7, 1'b1, 1'b0));
        cycle("over_drop", 1'b0, 1'b1, 1'b1, pack(3'd4, 2'd0, 4'd7, 1'b1, 1'b0));
        start_key = 1'b0;
        cycle("over_rel", 1'b0, 1'b0, 1'b0, pack(3'd4, 2'd0, 4'd7, 1'b1, 1'b0));
        start_key = 1'b1;
        cycle("over_key", 1'b0, 1'b0, 1'b0, pack(3'd1, 2'd0, 4'd7, 1'b1, 1'b0));

        // 5: simultaneous hit and last gold -> death, gold kept
        start_key = 1'b0;
        cycle("rel3", 1'b0, 1'b0, 1'b0, pack(3'd1, 2'd0, 4'd7, 1'b1, 1'b0));
        start_key = 1'b1;
        cycle("press3", 1'b0, 1'b0, 1'b0, pack(3'd2, 2'd3, 4'd8, 1'b0, 1'b1));
        for (int i = 1; i <= 7; i++)
            cycle("gold7", 1'b0, 1'b0, 1'b1, pack(3'd2, 2'd3, 4'(8 - i), 1'b0, 1'b0));
        cycle("hit_and_gold", 1'b0, 1'b1, 1'b1, pack(3'd2, 2'd2, 4'd1, 1'b1, 1'b0));
        cycle("death_drop", 1'b0, 1'b1, 1'b1, pack(3'd2, 2'd2, 4'd1, 1'b1, 1'b0));
        cycle("death_sof", 1'b1, 1'b0, 1'b0, pack(3'd2, 2'd2, 4'd1, 1'b1, 1'b0));

        // 6: reset during DEATH and during WIN
        resetN    = 1'b0;
        start_key = 1'b0;
        cycle("rst_death", 1'b0, 1'b0, 1'b0, rst_v);
        resetN = 1'b1;
        frames("blank2", 2, rst_v, pack(3'd1, 2'd3, 4'd8, 1'b1, 1'b0));
        start_key = 1'b1;
        cycle("press4", 1'b0, 1'b0, 1'b0, pack(3'd2, 2'd3, 4'd8, 1'b0, 1'b1));
        for (int i = 1; i <= 8; i++)
            cycle("gold8b", 1'b0, 1'b0, 1'b1,
                  pack((i == 8) ? 3'd3 : 3'd2, 2'd3, 4'(8 - i), (i == 8), 1'b0));
        cycle("win_sof", 1'b1, 1'b0, 1'b0, pack(3'd3, 2'd3, 4'd0, 1'b1, 1'b0));
        resetN = 1'b0;
        cycle("rst_win", 1'b0, 1'b0, 1'b0, rst_v);
        resetN = 1'b1;
        cycle("post_rst", 1'b0, 1'b0, 1'b0, rst_v);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
